// File: rtl/rx_ctrl_pkg.sv
// rtl/rx_ctrl_pkg.sv - shared types and constants for the receive link controller
package rx_ctrl_pkg;

    localparam int PHASE_W = 9;

    typedef enum logic [1:0] {
        CDR_ACQ       = 2'd0,
        COMMA_SEARCH  = 2'd1,
        ALIGN_CONFIRM = 2'd2,
        LINKED        = 2'd3
    } state_t;

    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    // Magnitude of the circular phase step; a step of exactly half the circle reads as 256.
    function automatic logic [PHASE_W-1:0] phase_abs_delta(input logic [PHASE_W-1:0] cur,
                                                           input logic [PHASE_W-1:0] prev);
        logic [PHASE_W-1:0] d;
        d = cur - prev;
        return d[PHASE_W-1] ? (~d + 1'b1) : d;
    endfunction

endpackage

// File: rtl/rx_link_controller_comma_detect.sv
// rtl/rx_link_controller_comma_detect.sv - combinational K28.5 search over a 20-bit window
module comma_detect
    import rx_ctrl_pkg::*;
(
    input  logic [19:0] i_window,
    output logic        o_found,
    output logic [3:0]  o_offset
);

    // Scan from the highest offset down so the lowest matching offset is written last.
    always_comb begin
        o_found  = 1'b0;
        o_offset = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (i_window[19-k -: 10] == K28_5_RDN || i_window[19-k -: 10] == K28_5_RDP) begin
                o_found  = 1'b1;
                o_offset = 4'(k);
            end
        end
    end

endmodule

// File: rtl/rx_link_controller.sv
// rtl/rx_link_controller.sv - CDR settle detection, comma alignment and link supervision
module rx_link_controller
    import rx_ctrl_pkg::*;
#(
    parameter int LOCK_WINDOW     = 4,
    parameter int LOCK_CYCLES     = 64,
    parameter int UNLOCK_WINDOW   = 16,
    parameter int COMMA_COUNT     = 3,
    parameter int CONFIRM_TIMEOUT = 128,
    parameter int ERR_LIMIT       = 4,
    parameter int GOOD_RUN        = 16
) (
    input  logic               RxBitCLK_10,
    input  logic               Reset,
    input  logic [PHASE_W-1:0] phase_shift,
    input  logic [9:0]         RxParallel_10,
    input  logic               Decode_Error,
    input  logic               Disparity_Error,
    output logic [3:0]         align_offset,
    output logic               cdr_lock,
    output logic               symbol_lock,
    output logic               link_up,
    output logic [1:0]         state
);

    localparam int SW = $clog2(LOCK_CYCLES + 1);
    localparam int CW = $clog2(COMMA_COUNT + 1);
    localparam int TW = $clog2(CONFIRM_TIMEOUT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam int GW = $clog2(GOOD_RUN + 1);

    localparam logic [PHASE_W-1:0] LOCK_WIN_C   = PHASE_W'(LOCK_WINDOW);
    localparam logic [PHASE_W-1:0] UNLOCK_WIN_C = PHASE_W'(UNLOCK_WINDOW);
    localparam logic [SW-1:0]      LOCK_CYC_C   = SW'(LOCK_CYCLES);
    localparam logic [CW-1:0]      COMMA_CNT_C  = CW'(COMMA_COUNT);
    localparam logic [TW-1:0]      TIMEOUT_C    = TW'(CONFIRM_TIMEOUT);
    localparam logic [EW-1:0]      ERR_LIMIT_C  = EW'(ERR_LIMIT);
    localparam logic [GW-1:0]      GOOD_RUN_C   = GW'(GOOD_RUN);

    state_t             r_state;
    logic [PHASE_W-1:0] r_last_phase;
    logic [9:0]         r_prev_word;
    logic [SW-1:0]      r_settle_cnt;
    logic [CW-1:0]      r_comma_cnt;
    logic [TW-1:0]      r_timeout_cnt;
    logic [EW-1:0]      r_err_cnt;
    logic [GW-1:0]      r_good_cnt;
    logic [3:0]         r_cand;

    logic [PHASE_W-1:0] w_abs_delta;
    logic               w_settled;
    logic               w_unlock;
    logic               w_found;
    logic [3:0]         w_offset;
    logic               w_err_word;
    logic [SW-1:0]      w_settle_nxt;
    logic [CW-1:0]      w_comma_nxt;
    logic [TW-1:0]      w_timeout_nxt;
    logic [EW-1:0]      w_err_nxt;
    logic [GW-1:0]      w_good_nxt;

    assign w_abs_delta   = phase_abs_delta(phase_shift, r_last_phase);
    assign w_settled     = (w_abs_delta <= LOCK_WIN_C);
    assign w_unlock      = (w_abs_delta > UNLOCK_WIN_C);
    assign w_err_word    = Decode_Error | Disparity_Error;
    assign w_settle_nxt  = r_settle_cnt + 1'b1;
    assign w_comma_nxt   = r_comma_cnt + 1'b1;
    assign w_timeout_nxt = r_timeout_cnt + 1'b1;
    assign w_err_nxt     = r_err_cnt + 1'b1;
    assign w_good_nxt    = r_good_cnt + 1'b1;
    assign state         = r_state;

    comma_detect u_comma_detect (
        .i_window ({r_prev_word, RxParallel_10}),
        .o_found  (w_found),
        .o_offset (w_offset)
    );

    always_ff @(posedge RxBitCLK_10 or posedge Reset) begin
        if (Reset) begin
            r_state       <= CDR_ACQ;
            r_last_phase  <= '0;
            r_prev_word   <= '0;
            r_settle_cnt  <= '0;
            r_comma_cnt   <= '0;
            r_timeout_cnt <= '0;
            r_err_cnt     <= '0;
            r_good_cnt    <= '0;
            r_cand        <= '0;
            align_offset  <= '0;
            cdr_lock      <= 1'b0;
            symbol_lock   <= 1'b0;
            link_up       <= 1'b0;
        end else begin
            r_last_phase <= phase_shift;
            r_prev_word  <= RxParallel_10;
            link_up      <= cdr_lock & symbol_lock;
            // Losing the CDR outranks every other transition, including error-driven drops.
            if (r_state != CDR_ACQ && w_unlock) begin
                r_state       <= CDR_ACQ;
                cdr_lock      <= 1'b0;
                symbol_lock   <= 1'b0;
                r_settle_cnt  <= '0;
                r_comma_cnt   <= '0;
                r_timeout_cnt <= '0;
                r_err_cnt     <= '0;
                r_good_cnt    <= '0;
            end else begin
                case (r_state)
                    CDR_ACQ: begin
                        if (!w_settled) begin
                            r_settle_cnt <= '0;
                        end else if (w_settle_nxt == LOCK_CYC_C) begin
                            r_settle_cnt  <= '0;
                            r_comma_cnt   <= '0;
                            r_timeout_cnt <= '0;
                            cdr_lock      <= 1'b1;
                            r_state       <= COMMA_SEARCH;
                        end else begin
                            r_settle_cnt <= w_settle_nxt;
                        end
                    end
                    COMMA_SEARCH: begin
                        if (w_found) begin
                            r_cand        <= w_offset;
                            r_comma_cnt   <= CW'(1);
                            r_timeout_cnt <= '0;
                            r_state       <= ALIGN_CONFIRM;
                        end
                    end
                    ALIGN_CONFIRM: begin
                        if (w_found) begin
                            r_timeout_cnt <= '0;
                            if (w_offset != r_cand) begin
                                r_cand      <= w_offset;
                                r_comma_cnt <= CW'(1);
                            end else begin
                                r_comma_cnt <= w_comma_nxt;
                                if (w_comma_nxt == COMMA_CNT_C) begin
                                    align_offset <= r_cand;
                                    symbol_lock  <= 1'b1;
                                    r_err_cnt    <= '0;
                                    r_good_cnt   <= '0;
                                    r_state      <= LINKED;
                                end
                            end
                        end else if (w_timeout_nxt == TIMEOUT_C) begin
                            r_timeout_cnt <= '0;
                            r_state       <= COMMA_SEARCH;
                        end else begin
                            r_timeout_cnt <= w_timeout_nxt;
                        end
                    end
                    LINKED: begin
                        if (w_err_word) begin
                            r_good_cnt <= '0;
                            if (w_err_nxt == ERR_LIMIT_C) begin
                                r_err_cnt   <= '0;
                                symbol_lock <= 1'b0;
                                r_state     <= COMMA_SEARCH;
                            end else begin
                                r_err_cnt <= w_err_nxt;
                            end
                        end else if (w_good_nxt == GOOD_RUN_C) begin
                            r_good_cnt <= '0;
                            if (r_err_cnt != '0) r_err_cnt <= r_err_cnt - 1'b1;
                        end else begin
                            r_good_cnt <= w_good_nxt;
                        end
                    end
                    default: r_state <= CDR_ACQ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_link_controller.sv
// tb/tb_rx_link_controller.sv - self-checking bench for rx_link_controller
module tb_rx_link_controller;

    localparam logic [9:0] RDN = 10'b0011111010;
    localparam logic [9:0] RDP = 10'b1100000101;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] ph = '0;
    logic [9:0] word = '0;
    logic       de = 1'b0;
    logic       pe = 1'b0;
    logic [3:0] off;
    logic       cdr, sym, lnk;
    logic [1:0] st;

    int checks = 0;
    int failures = 0;

    int m_state, m_cdr, m_sym, m_link, m_off, m_last, m_prev;
    int m_settle, m_cand, m_ccnt, m_to, m_err, m_good;

    always #5 clk = ~clk;

    rx_link_controller dut (
        .RxBitCLK_10     (clk),
        .Reset           (rst),
        .phase_shift     (ph),
        .RxParallel_10   (word),
        .Decode_Error    (de),
        .Disparity_Error (pe),
        .align_offset    (off),
        .cdr_lock        (cdr),
        .symbol_lock     (sym),
        .link_up         (lnk),
        .state           (st)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: evaluates the link rules on each sampled word.
    always @(posedge clk or posedge rst) begin
        int d, found, cw;
        logic [19:0] win;
        if (rst) begin
            m_state = 0; m_cdr = 0; m_sym = 0; m_link = 0; m_off = 0; m_last = 0; m_prev = 0;
            m_settle = 0; m_cand = 0; m_ccnt = 0; m_to = 0; m_err = 0; m_good = 0;
        end else begin
            d = (int'(ph) - m_last + 512) % 512;
            if (d >= 256) d = 512 - d;
            m_last = int'(ph);
            win = {10'(m_prev), word};
            found = -1;
            for (int k = 0; k < 10; k++) begin
                cw = int'((win >> (10 - k)) & 20'h003FF);
                if (found < 0 && (cw == int'(RDN) || cw == int'(RDP))) found = k;
            end
            m_prev = int'(word);
            m_link = m_cdr & m_sym;
            if (m_state != 0 && d > 16) begin
                m_state = 0; m_cdr = 0; m_sym = 0;
                m_settle = 0; m_ccnt = 0; m_to = 0; m_err = 0; m_good = 0;
            end else begin
                case (m_state)
                    0: begin
                        if (d <= 4) begin
                            m_settle++;
                            if (m_settle == 64) begin m_cdr = 1; m_state = 1; m_settle = 0; end
                        end else m_settle = 0;
                    end
                    1: if (found >= 0) begin m_cand = found; m_ccnt = 1; m_to = 0; m_state = 2; end
                    2: begin
                        if (found >= 0) begin
                            m_to = 0;
                            if (found == m_cand) m_ccnt++;
                            else begin m_cand = found; m_ccnt = 1; end
                            if (m_ccnt == 3) begin
                                m_off = m_cand; m_sym = 1; m_state = 3; m_err = 0; m_good = 0;
                            end
                        end else begin
                            m_to++;
                            if (m_to == 128) begin m_state = 1; m_to = 0; end
                        end
                    end
                    default: begin
                        if (de | pe) begin
                            m_good = 0;
                            if (m_err < 4) m_err++;
                            if (m_err == 4) begin m_sym = 0; m_state = 1; m_err = 0; end
                        end else begin
                            m_good++;
                            if (m_good == 16) begin m_good = 0; if (m_err > 0) m_err--; end
                        end
                    end
                endcase
            end
        end
        #1;
        check("m_state", int'(st), m_state);
        check("m_cdr_lock", int'(cdr), m_cdr);
        check("m_symbol_lock", int'(sym), m_sym);
        check("m_link_up", int'(lnk), m_link);
        check("m_align_offset", int'(off), m_off);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        word = '0; de = 1'b0; pe = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; ph = '0; word = '0; de = 1'b0; pe = 1'b0;
        tick(); tick();
        check("rst_state", int'(st), 0);
        check("rst_cdr", int'(cdr), 0);
        check("rst_sym", int'(sym), 0);
        check("rst_link", int'(lnk), 0);
        check("rst_off", int'(off), 0);
        rst = 1'b0;
    endtask

    task automatic comma_at(input int k, input bit rdp);
        logic [19:0] w;
        w = 20'(rdp ? RDP : RDN) << (10 - k);
        word = w[19:10]; tick();
        word = w[9:0];   tick();
        word = '0;
    endtask

    initial begin
        logic [19:0] w;
        logic [9:0]  pend;
        bit          have_pend;
        int          kk, step;

        // Constant phase: lock on word 64
        do_reset();
        ph = 9'd100;
        repeat (64) tick();
        check("const_cdr_w63", int'(cdr), 0);
        tick();
        check("const_cdr_w64", int'(cdr), 1);
        check("const_state_w64", int'(st), 1);

        // Jump at word 30 restarts settling: lock on word 94
        do_reset();
        ph = 9'd100;
        repeat (30) tick();
        ph = 9'd110;
        repeat (64) tick();
        check("jump_cdr_w93", int'(cdr), 0);
        tick();
        check("jump_cdr_w94", int'(cdr), 1);

        // Ramp through the 511->0 wrap stays settled; 508 from 0 is |d|=4
        do_reset();
        ph = 9'd508;
        repeat (63) begin tick(); ph = ph + 9'd1; end
        check("wrap_cdr_w62", int'(cdr), 0);
        tick();
        check("wrap_cdr_w63", int'(cdr), 1);

        // Commas at offset 3 in words 1, 5, 9
        comma_at(3, 1'b0);
        idle(2);
        comma_at(3, 1'b0);
        idle(2);
        w = 20'(RDN) << 7;
        word = w[19:10]; tick();
        check("align_sym_w8", int'(sym), 0);
        check("align_state_w8", int'(st), 2);
        word = w[9:0]; tick();
        check("align_sym_w9", int'(sym), 1);
        check("align_off_w9", int'(off), 3);
        check("align_state_w9", int'(st), 3);
        check("align_link_w9", int'(lnk), 0);
        idle(1);
        check("align_link_w10", int'(lnk), 1);

        // Clean runs of 16 keep the error count from reaching the limit
        pe = 1'b1; tick(); pe = 1'b0;
        de = 1'b1; tick();
        repeat (3) begin idle(16); de = 1'b1; tick(); end
        idle(32);
        check("good_run_state", int'(st), 3);
        check("good_run_sym", int'(sym), 1);

        // Four errors with under 16 clean words between them drop symbol lock
        de = 1'b1; tick(); idle(3);
        de = 1'b1; tick(); tick();
        check("err3_state", int'(st), 3);
        tick();
        check("err4_state", int'(st), 1);
        check("err4_sym", int'(sym), 0);
        check("err4_cdr", int'(cdr), 1);
        check("err4_off_hold", int'(off), 3);
        idle(1);
        check("err4_link", int'(lnk), 0);

        // Re-candidate at offset 7, then time out back to search
        comma_at(3, 1'b0);
        comma_at(7, 1'b1);
        check("recand_state", int'(st), 2);
        repeat (127) tick();
        check("timeout_state_127", int'(st), 2);
        tick();
        check("timeout_state_128", int'(st), 1);

        // Relink at offset 5, then a phase jump on the 4th error wins
        comma_at(5, 1'b1); idle(1);
        comma_at(5, 1'b1); idle(1);
        comma_at(5, 1'b1);
        check("relink_state", int'(st), 3);
        check("relink_off", int'(off), 5);
        de = 1'b1; repeat (3) tick();
        ph = ph + 9'd40; tick();
        check("cdrloss_state", int'(st), 0);
        check("cdrloss_cdr", int'(cdr), 0);
        check("cdrloss_sym", int'(sym), 0);
        idle(1);
        check("cdrloss_link", int'(lnk), 0);

        // Asynchronous reset in the middle of ALIGN_CONFIRM
        idle(70);
        check("reacq_state", int'(st), 1);
        comma_at(3, 1'b0);
        check("preasync_state", int'(st), 2);
        #1 rst = 1'b1;
        #1;
        check("async_state", int'(st), 0);
        check("async_cdr", int'(cdr), 0);
        check("async_sym", int'(sym), 0);
        check("async_link", int'(lnk), 0);
        check("async_off", int'(off), 0);
        tick();
        rst = 1'b0;

        // Randomized traffic against the model
        have_pend = 1'b0;
        pend = '0;
        for (int n = 0; n < 4000; n++) begin
            if (have_pend) begin
                word = pend; have_pend = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                kk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 2;
                w = 20'($urandom_range(0, 1) ? RDP : RDN) << (10 - kk);
                word = w[19:10]; pend = w[9:0]; have_pend = 1'b1;
            end else begin
                word = $urandom_range(0, 1) ? 10'($urandom) : 10'd0;
            end
            if ($urandom_range(0, 199) == 0) step = int'($urandom_range(17, 200));
            else if ($urandom_range(0, 19) == 0) step = int'($urandom_range(5, 12));
            else step = int'($urandom_range(0, 6)) - 3;
            if ($urandom_range(0, 1) == 0) step = -step;
            ph = ph + 9'(step);
            de = ($urandom_range(0, 19) == 0);
            pe = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
